// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst master feeding the SDRAM controller slave port.
// Takes burst commands plus a write-data stream, returns read data as a stream, aborts stalled bursts.
module wb_burst_master #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned APP_AW      = 26,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    sys_clk,
  input  logic                    sys_resetn,
  input  logic                    sdr_init_done,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [APP_AW-1:0]       cmd_addr,
  input  logic [3:0]              cmd_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_sel,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    err,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [APP_AW-1:0]       wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [2:0]              wb_cti_o,
  input  logic                    wb_ack_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e                  state_q, state_d;
  logic [APP_AW-1:0]       addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic [2:0]              cti_q, cti_d;
  logic [4:0]              beats_q, beats_d;
  logic [4:0]              left_q, left_d;
  logic [4:0]              loaded_q, loaded_d;
  logic                    dvalid_q, dvalid_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_last_q, rd_last_d;
  logic                    err_q, err_d;

  logic ack;
  logic wr_hs;
  logic tmo_hit;

  // Acks are only meaningful while a beat is being presented.
  assign ack       = wb_ack_i && stb_q;
  assign cmd_ready = (state_q == IDLE) && sdr_init_done;
  assign wr_ready  = (state_q == WR) && (loaded_q < beats_q) && (!dvalid_q || ack);
  assign wr_hs     = wr_valid && wr_ready;
  assign tmo_hit   = stb_q && !wb_ack_i && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    cti_d      = cti_q;
    beats_d    = beats_q;
    left_d     = left_q;
    loaded_d   = loaded_q;
    dvalid_d   = dvalid_q;
    tmo_d      = tmo_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_last_d  = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d   = cmd_addr;
          we_d     = cmd_we;
          beats_d  = 5'(cmd_len) + 5'd1;
          left_d   = 5'(cmd_len) + 5'd1;
          loaded_d = '0;
          dvalid_d = 1'b0;
          tmo_d    = '0;
          cyc_d    = 1'b1;
          cti_d    = (cmd_len == 4'd0) ? CTI_END : CTI_INCR;
          if (cmd_we) begin
            state_d = WR;
            stb_d   = 1'b0;
          end else begin
            state_d = RD;
            stb_d   = 1'b1;
            sel_d   = '1;
          end
        end
      end
      RD, WR: begin
        if (ack) begin
          addr_d = addr_q + APP_AW'(SW);
          left_d = left_q - 5'd1;
          tmo_d  = '0;
          cti_d  = (left_q > 5'd2) ? CTI_INCR : CTI_END;
        end else if (stb_q) begin
          tmo_d = tmo_q + TW'(1);
        end
        if (state_q == RD && ack) begin
          rd_valid_d = 1'b1;
          rd_data_d  = wb_dat_i;
          rd_last_d  = (left_q == 5'd1);
        end
        // Single holding register: reload on the ack cycle keeps stb high for back-to-back beats.
        if (state_q == WR) begin
          if (wr_hs) begin
            dat_d    = wr_data;
            sel_d    = wr_sel;
            dvalid_d = 1'b1;
            loaded_d = loaded_q + 5'd1;
          end else if (ack) begin
            dvalid_d = 1'b0;
          end
          stb_d = dvalid_d;
        end
        if ((ack && left_q == 5'd1) || tmo_hit) begin
          state_d  = IDLE;
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          dvalid_d = 1'b0;
          cti_d    = 3'b000;
          tmo_d    = '0;
          err_d    = tmo_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      dat_q      <= '0;
      sel_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      cti_q      <= 3'b000;
      beats_q    <= '0;
      left_q     <= '0;
      loaded_q   <= '0;
      dvalid_q   <= 1'b0;
      tmo_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      cti_q      <= cti_d;
      beats_q    <= beats_d;
      left_q     <= left_d;
      loaded_q   <= loaded_d;
      dvalid_q   <= dvalid_d;
      tmo_q      <= tmo_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      err_q      <= err_d;
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_cti_o  = cti_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign err       = err_q;

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Wishbone master that sits directly upstream of the SDRAM controller's Wishbone slave port.
- Accepts read/write burst commands and a write-data stream from test or application logic.
- Drives classic Wishbone incrementing bursts (wb_cti) into the controller and returns read data as a stream.
- Holds off all traffic until the controller reports sdr_init_done; aborts hung bursts with a timeout.

Parameters:
- DATA_WIDTH, 32, Wishbone data width in bits (multiple of 8).
- APP_AW, 26, Wishbone byte address width.
- TIMEOUT_CYC, 1024, cycles without wb_ack_i before a burst is aborted (>=2).

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_resetn  input  1  asynchronous active-low reset.
- sdr_init_done  input  1  controller initialisation complete.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
- cmd_we  input  1  1=write burst, 0=read burst.
- cmd_addr  input  APP_AW  start byte address, beat-aligned.
- cmd_len  input  4  beats minus one (1..16 beats).
- wr_valid  input  1  write data available.
- wr_ready  output  1  write beat accepted.
- wr_data  input  DATA_WIDTH  write data.
- wr_sel  input  DATA_WIDTH/8  write byte enables.
- rd_valid  output  1  read beat valid (no backpressure).
- rd_data  output  DATA_WIDTH  read data.
- rd_last  output  1  final beat of read burst.
- err  output  1  one-cycle pulse on timeout abort.
- wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone control.
- wb_addr_o  output  APP_AW  Wishbone address.
- wb_dat_o  output  DATA_WIDTH  Wishbone write data.
- wb_sel_o  output  DATA_WIDTH/8  Wishbone byte select.
- wb_cti_o  output  3  cycle type.
- wb_ack_i  input  1  slave acknowledge.
- wb_dat_i  input  DATA_WIDTH  slave read data.

Behaviour:
- Reset (async, immediate, any state): state IDLE; all outputs 0; counters 0.
- States: IDLE, RD, WR.
- IDLE:
  - cmd_ready = sdr_init_done.
  - On handshake: latch addr, we, beats = cmd_len+1, beats_left = beats, loaded = 0.
  - Next state RD or WR. cmd_ready is 0 outside IDLE.
- Wishbone outputs are registered.
  - wb_cyc_o = 1 for the whole RD/WR burst.
  - wb_cti_o = 3'b010 while beats_left>1, 3'b111 on the last beat (a 1-beat burst uses 3'b111).
  - wb_sel_o = all ones on reads.
  - wb_addr_o advances by DATA_WIDTH/8 on each ack; wraps modulo 2^APP_AW.
- RD:
  - wb_stb_o = 1, wb_we_o = 0 from the cycle after the command handshake.
  - Each wb_ack_i: rd_valid = 1 and rd_data = wb_dat_i one cycle later; beats_left decrements.
  - rd_last accompanies the final beat.
  - After the final ack, cyc/stb drop next cycle and the state returns to IDLE.
- WR:
  - Single-entry data register with flag dvalid.
  - wr_ready = state==WR && loaded<beats && (!dvalid || wb_ack_i).
  - On a wr handshake: load wr_data/wr_sel to wb_dat_o/wb_sel_o, set dvalid, increment loaded.
  - wb_stb_o = dvalid, wb_we_o = 1.
  - On ack without reload: clear dvalid. Ack and reload in the same cycle keeps stb high (back-to-back beats).
  - Final ack: return to IDLE as in RD.
- wb_ack_i while wb_stb_o=0 is ignored.
- Timeout:
  - Counter clears on every ack and on burst entry; counts while stb=1 and no ack.
  - Reaching TIMEOUT_CYC: cyc/stb drop next cycle, err pulses 1 cycle, state IDLE, dvalid cleared.
  - Unconsumed write beats remain upstream (upstream must flush them).
- sdr_init_done deasserting mid-burst has no effect until the burst completes; it blocks only new commands.
- Latency:
  - Command handshake to first stb: 1 cycle (RD); 1 cycle after first wr handshake (WR).
  - Ack to rd_valid: 1 cycle.

Test Plan:
- Init gate: sdr_init_done=0, cmd_valid=1 for 50 cycles -> cmd_ready=0, wb_cyc_o=0. Raise sdr_init_done -> accepted same cycle.
- Read burst: cmd_we=0, addr=0x100, len=3, slave acks every cycle.
  - wb_addr_o = 0x100,0x104,0x108,0x10C.
  - cti = 010,010,010,111.
  - 4 rd_valid pulses; rd_last on the 4th.
  - cyc low after the 4th ack.
- Write with gaps: len=1, wr_valid held low 5 cycles then high.
  - stb stays low until data is loaded.
  - Slave ack every other cycle -> both beats written with the correct wb_sel_o.
  - Exactly 2 wr_ready handshakes.
- Single beat: len=0 write at addr 0x3FFFFFC -> cti=111; address wraps to 0 internally; returns to IDLE.
- Timeout: TIMEOUT_CYC=16, read, slave never acks -> cyc drops after 16 stall cycles, err pulses once, cmd_ready returns.
- Async reset mid-burst: assert sys_resetn low during beat 2 of an 8-beat write -> all outputs 0 immediately; next command behaves normally.
